// File: rtl/ram32x4_loader_if.sv
// ram32x4_loader_if
//   Bundles the two buses the loader sits between: the inbound 4-bit
//   valid/ready stream from the boot/config source and the port of the
//   32x4 sync-write / async-read LUT RAM.
//   Signals:
//     din, din_valid  stream data and its valid qualifier (source -> loader)
//     din_ready       loader accepts din this cycle      (loader -> source)
//     ram_ad          RAM address, shared by write and read
//     ram_di, ram_wre RAM write data and write enable    (loader -> RAM)
//     ram_do          RAM asynchronous read data          (RAM -> loader)
//   Modports: master = the loader, slave = the stream source plus the RAM.
interface ram32x4_loader_if #(
  parameter int AW = 5,
  parameter int DW = 4
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_di;
  logic          ram_wre;
  logic [DW-1:0] ram_do;

  modport master (
    input  din, din_valid, ram_do,
    output din_ready, ram_ad, ram_di, ram_wre
  );

  modport slave (
    output din, din_valid, ram_do,
    input  din_ready, ram_ad, ram_di, ram_wre
  );
endinterface

// File: rtl/ram32x4_loader.sv
// ram32x4_loader
//   Fills a 2**AW x DW sync-write / async-read RAM from a valid/ready nibble
//   stream, optionally reads every word back to confirm the running sum, and
//   reports an 8-bit checksum of the loaded data.
//   Ports:
//     ck      clock, all state changes on the rising edge
//     rstn    synchronous active-low reset (RAM contents are left alone)
//     start   begin a load; only looked at while idle
//     bus     stream + RAM port bundle (master side)
//     busy    high while loading, verifying or finishing
//     done    single-cycle pulse at the end of an operation
//     err     read-back sum differed from load sum; sticky until next start
//     chksum  sum of loaded words mod 256, held after done
module ram32x4_loader #(
  parameter int AW     = 5,
  parameter int DW     = 4,
  parameter bit VERIFY = 1'b1
) (
  input  logic                 ck,
  input  logic                 rstn,
  input  logic                 start,
  ram32x4_loader_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           chksum
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [7:0]    wsum_r;
  logic [7:0]    vsum_r;
  logic [7:0]    chksum_r;
  logic          err_r;
  logic          done_r;
  logic          busy_r;
  logic          ready_r;

  logic          hs_s;
  logic [7:0]    wsum_next_s;
  logic [7:0]    vsum_next_s;

  // Zero-extend a RAM word and add it to an 8-bit running sum; carries
  // past bit 7 are dropped.
  function automatic logic [7:0] add_word(input logic [7:0] sum,
                                          input logic [DW-1:0] word);
    logic [7:0] ext;
    ext = 8'(word);
    return sum + ext;
  endfunction

  // Stream handshake drives the RAM write directly so a word lands in the
  // same cycle it is accepted.
  assign hs_s        = bus.din_valid & ready_r;
  assign wsum_next_s = add_word(wsum_r, bus.din);
  assign vsum_next_s = add_word(vsum_r, bus.ram_do);

  // Bus and status outputs; everything except the write strobe/data comes
  // straight from registers.
  assign bus.din_ready = ready_r;
  assign bus.ram_wre   = hs_s;
  assign bus.ram_ad    = addr_r;
  assign bus.ram_di    = bus.din;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign chksum        = chksum_r;

  // Loader FSM with its registered outputs (ready, busy, done, err, chksum).
  always_ff @(posedge ck) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      addr_r   <= {AW{1'b0}};
      wsum_r   <= 8'h00;
      vsum_r   <= 8'h00;
      chksum_r <= 8'h00;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD;
            addr_r  <= {AW{1'b0}};
            wsum_r  <= 8'h00;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (hs_s) begin
            wsum_r <= wsum_next_s;
            // Natural wrap returns addr to 0 after the last word, which is
            // also where the read-back pass starts.
            addr_r <= addr_r + 1'b1;
            if (addr_r == LAST_ADDR) begin
              ready_r <= 1'b0;
              vsum_r  <= 8'h00;
              if (VERIFY) begin
                state_r <= ST_VERIFY;
              end else begin
                state_r  <= ST_FINISH;
                done_r   <= 1'b1;
                chksum_r <= wsum_next_s;
              end
            end
          end
        end
        ST_VERIFY: begin
          vsum_r <= vsum_next_s;
          addr_r <= addr_r + 1'b1;
          // Last read: include this cycle's word in the comparison.
          if (addr_r == LAST_ADDR) begin
            err_r    <= (vsum_next_s != wsum_r);
            chksum_r <= wsum_r;
            done_r   <= 1'b1;
            state_r  <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          addr_r  <= {AW{1'b0}};
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram32x4_loader.sv
// tb_ram32x4_loader
//   Directed bench for ram32x4_loader: a verifying instance with a behavioural
//   32x4 RAM (with an optional bit-0 fault on word 7) and a non-verifying
//   instance sharing the stream inputs.
module tb_ram32x4_loader;

  logic       ck = 1'b0;
  logic       rstn;
  logic       start;
  logic       start_nv;
  logic [3:0] din;
  logic       din_valid;
  logic       flip;

  logic       busy, done, err;
  logic [7:0] chksum;
  logic       busy_nv, done_nv, err_nv;
  logic [7:0] chksum_nv;

  logic [3:0] mem [0:31];

  int checks   = 0;
  int failures = 0;

  ram32x4_loader_if #(.AW(5), .DW(4)) bus ();
  ram32x4_loader_if #(.AW(5), .DW(4)) bus_nv ();

  assign bus.din          = din;
  assign bus.din_valid    = din_valid;
  assign bus.ram_do       = mem[bus.ram_ad] ^ ((flip && bus.ram_ad == 5'd7) ? 4'h1 : 4'h0);
  assign bus_nv.din       = din;
  assign bus_nv.din_valid = din_valid;
  assign bus_nv.ram_do    = 4'h0;

  ram32x4_loader #(.AW(5), .DW(4), .VERIFY(1'b1)) dut (
    .ck(ck), .rstn(rstn), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .chksum(chksum)
  );

  ram32x4_loader #(.AW(5), .DW(4), .VERIFY(1'b0)) dut_nv (
    .ck(ck), .rstn(rstn), .start(start_nv), .bus(bus_nv),
    .busy(busy_nv), .done(done_nv), .err(err_nv), .chksum(chksum_nv)
  );

  always #5 ck = ~ck;

  // Behavioural RAM: synchronous write
  always @(posedge ck) begin
    if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_di;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Stream nwords nibbles; expects a write exactly on each valid cycle at the next address
  task automatic feed(input bit all_f, input bit gap, input bit poke, input int nwords);
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    while (idx < nwords && cyc < 300) begin
      din_valid = gap ? (cyc % 2 == 0) : 1'b1;
      din       = all_f ? 4'hF : idx[3:0];
      start     = poke && (cyc % 5 == 3);
      #1;
      if (bus.ram_wre !== din_valid) bad++;
      if (bus.ram_ad !== idx[4:0]) bad++;
      if (bus.ram_di !== din) bad++;
      if (bus.din_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
      if (din_valid) idx++;
      @(posedge ck);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("load_seq", bad, 0);
    chk("load_words", idx, nwords);
    chk("load_cycles", cyc, gap ? 2 * nwords - 1 : nwords);
  endtask

  // 32 read-back cycles: address 0..31, no writes, no ready, no done
  task automatic verify_phase(input bit poke);
    int bad = 0;
    for (int k = 0; k < 32; k++) begin
      din_valid = 1'b1;
      start     = poke && (k % 7 == 2);
      #1;
      if (bus.ram_ad !== k[4:0]) bad++;
      if (bus.ram_wre !== 1'b0 || bus.din_ready !== 1'b0) bad++;
      if (done !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge ck);
      #1;
    end
    start     = 1'b0;
    din_valid = 1'b0;
    chk("verify_seq", bad, 0);
  endtask

  task automatic finish_phase(input logic [7:0] exp_ck, input logic exp_err, input bit poke);
    start = poke;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("busy_finish", busy, 1'b1);
    chk("chksum_done", chksum, exp_ck);
    chk("err_done", err, exp_err);
    step();
    start = 1'b0;
    chk("done_low", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("chksum_hold", chksum, exp_ck);
    chk("err_hold", err, exp_err);
    step();
    chk("idle_stays", busy, 1'b0);
  endtask

  initial begin
    int bad;
    rstn = 1'b0; start = 1'b0; start_nv = 1'b0;
    din = 4'h0; din_valid = 1'b0; flip = 1'b0;
    step();
    step();
    rstn = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_chksum", chksum, 8'h00);
    chk("rst_ad", bus.ram_ad, 5'd0);

    // 1: reset in the middle of random stimulus
    kick();
    for (int i = 0; i < 8; i++) begin
      din = 4'($urandom); din_valid = 1'($urandom); start = 1'($urandom);
      step();
    end
    rstn = 1'b0;
    step();
    din = 4'($urandom); din_valid = 1'b1; start = 1'b1;
    step();
    #1;
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done, 1'b0);
    chk("t1_err", err, 1'b0);
    chk("t1_wre", bus.ram_wre, 1'b0);
    chk("t1_ready", bus.din_ready, 1'b0);
    chk("t1_ad", bus.ram_ad, 5'd0);
    chk("t1_chksum", chksum, 8'h00);
    start = 1'b0; din_valid = 1'b0;
    rstn = 1'b1;
    step();

    // 2: back-to-back load of 0..F twice
    kick();
    chk("t2_ready", bus.din_ready, 1'b1);
    feed(1'b0, 1'b0, 1'b0, 32);
    verify_phase(1'b0);
    finish_phase(8'hF0, 1'b0, 1'b0);

    // 3: same data, valid every other cycle
    kick();
    feed(1'b0, 1'b1, 1'b0, 32);
    verify_phase(1'b0);
    finish_phase(8'hF0, 1'b0, 1'b0);

    // 4: all 0xF, word 7 reads back with bit0 flipped
    kick();
    feed(1'b1, 1'b0, 1'b0, 32);
    flip = 1'b1;
    verify_phase(1'b0);
    finish_phase(8'hE0, 1'b1, 1'b0);
    flip = 1'b0;
    step();
    step();
    chk("t4_err_sticky", err, 1'b1);
    kick();
    chk("t4_err_clear", err, 1'b0);
    chk("t4_chksum_keep", chksum, 8'hE0);
    chk("t4_busy", busy, 1'b1);

    // 5: reset after the 10th accepted nibble
    feed(1'b0, 1'b0, 1'b0, 10);
    rstn = 1'b0;
    din_valid = 1'b1;
    step();
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_err", err, 1'b0);
    chk("t5_ad", bus.ram_ad, 5'd0);
    chk("t5_wre", bus.ram_wre, 1'b0);
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("t5_quiet", bad, 0);
    din_valid = 1'b0;
    kick();
    feed(1'b0, 1'b0, 1'b0, 32);
    verify_phase(1'b0);
    finish_phase(8'hF0, 1'b0, 1'b0);

    // 6: start pokes during load, verify and finish are ignored
    kick();
    feed(1'b0, 1'b0, 1'b1, 32);
    verify_phase(1'b1);
    finish_phase(8'hF0, 1'b0, 1'b1);

    // 6b: no-verify build finishes one cycle after the 32nd write
    start_nv = 1'b1;
    step();
    start_nv = 1'b0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      din = k[3:0]; din_valid = 1'b1;
      #1;
      if (bus_nv.ram_wre !== 1'b1 || bus_nv.ram_ad !== k[4:0]) bad++;
      if (done_nv !== 1'b0 || busy_nv !== 1'b1) bad++;
      if (busy !== 1'b0) bad++;
      step();
    end
    din_valid = 1'b0;
    #1;
    chk("nv_seq", bad, 0);
    chk("nv_done", done_nv, 1'b1);
    chk("nv_wre", bus_nv.ram_wre, 1'b0);
    chk("nv_chksum", chksum_nv, 8'hF0);
    chk("nv_err", err_nv, 1'b0);
    step();
    chk("nv_done_low", done_nv, 1'b0);
    chk("nv_busy_low", busy_nv, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
